magic_ctl: RTL and testbench

Parametrised "magic" supervisor: it arbitrates several NMI trigger sources and drives the CPU NMI line. It maps the magic ROM/RAM on the NMI vector fetch and unmaps it on exit fetches. It also hosts a generic readable/writable 8-bit configuration register file, accessible only while magic is mapped. It sits between the CPU bus decoder and the memory/feature blocks, and supersedes the fixed-function magic controller.

---
 rtl/magic_ctl_pkg.sv | 17 +
 rtl/cpu_bus.sv | 12 +
 rtl/magic_cfg_regs.sv | 81 ++++++++
 rtl/magic_ctl.sv | 165 ++++++++++++++++
 tb/tb_magic_ctl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/magic_ctl_pkg.sv
// Shared types and default addresses for the magic supervisor.
package magic_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PENDING,
    ST_ACTIVE,
    ST_UNMAP_WAIT,
    ST_REENTER
  } magic_state_t;

  localparam logic [15:0] MAGIC_NMI_VECTOR   = 16'h0066;
  localparam logic [15:0] MAGIC_EXIT_ADDR    = 16'hF000;
  localparam logic [15:0] MAGIC_REENTER_ADDR = 16'hF008;
  localparam logic [7:0]  MAGIC_CFG_PORT     = 8'hFF;

endpackage

// File: rtl/cpu_bus.sv
// CPU bus as seen by the magic supervisor (all strobes active high).
interface cpu_bus;
  logic        memreq;
  logic        ioreq;
  logic        m1;
  logic        rd;
  logic        wr;
  logic [15:0] a_reg;
  logic [7:0]  d_reg;

  modport slave (input memreq, ioreq, m1, rd, wr, a_reg, d_reg);
endinterface

// File: rtl/magic_cfg_regs.sv
// Config register file: edge-detected writes with one-cycle strobes, registered readback.
module magic_cfg_regs
  import magic_ctl_pkg::*;
#(
  parameter int                    NUM_REGS  = 16,
  parameter logic [NUM_REGS*8-1:0] CFG_RESET = '0
) (
  input  logic                    clk28,
  input  logic                    rst_n,
  input  logic                    cs_i,
  input  logic                    wr_i,
  input  logic                    rd_i,
  input  logic [7:0]              idx_i,
  input  logic [7:0]              d_i,
  input  logic [7:0]              cause_i,
  output logic [NUM_REGS*8-1:0]   cfg_o,
  output logic [NUM_REGS-1:0]     cfg_wr_o,
  output logic [7:0]              d_out_o,
  output logic                    d_out_active_o
);

  logic [NUM_REGS-1:0][7:0] regs_q;
  logic [NUM_REGS-1:0]      wr_q;
  logic                     wr_prev_q;
  logic                     wr_go;
  logic [7:0]               d_out_q;
  logic                     act_q;
  logic                     rd_hit;
  logic [7:0]               rd_data;

  // A write held across several cycles counts as one access.
  assign wr_go = cs_i && wr_i && !wr_prev_q;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      regs_q    <= CFG_RESET;
      wr_q      <= '0;
      wr_prev_q <= 1'b0;
    end else begin
      wr_prev_q <= cs_i && wr_i;
      for (int i = 0; i < NUM_REGS; i++) begin
        wr_q[i] <= wr_go && (idx_i == 8'(i));
        if (wr_go && (idx_i == 8'(i))) regs_q[i] <= d_i;
      end
    end
  end

  always_comb begin
    rd_hit  = 1'b0;
    rd_data = 8'hFF;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_i == 8'(i)) begin
        rd_hit  = 1'b1;
        rd_data = regs_q[i];
      end
    end
    if (idx_i == MAGIC_CFG_PORT) begin
      rd_hit  = 1'b1;
      rd_data = cause_i;
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      d_out_q <= 8'hFF;
      act_q   <= 1'b0;
    end else if (cs_i && rd_i && rd_hit) begin
      d_out_q <= rd_data;
      act_q   <= 1'b1;
    end else begin
      d_out_q <= 8'hFF;
      act_q   <= 1'b0;
    end
  end

  assign cfg_o          = regs_q;
  assign cfg_wr_o       = wr_q;
  assign d_out_o        = d_out_q;
  assign d_out_active_o = act_q;

endmodule

// File: rtl/magic_ctl.sv
// Magic supervisor: NMI arbitration, magic memory map/unmap FSM and config port.
module magic_ctl
  import magic_ctl_pkg::*;
#(
  parameter int                    NMI_SRC      = 2,
  parameter logic [NMI_SRC-1:0]    SYNC_MASK    = NMI_SRC'(1),
  parameter int                    NUM_REGS     = 16,
  parameter logic [NUM_REGS*8-1:0] CFG_RESET    = '0,
  parameter logic [15:0]           NMI_VECTOR   = MAGIC_NMI_VECTOR,
  parameter logic [15:0]           EXIT_ADDR    = MAGIC_EXIT_ADDR,
  parameter logic [15:0]           REENTER_ADDR = MAGIC_REENTER_ADDR,
  parameter int                    NMI_TIMEOUT  = 4096
) (
  input  logic                  clk28,
  input  logic                  rst_n,
  cpu_bus.slave                 bus,
  input  logic                  n_int,
  input  logic                  n_int_next,
  input  logic [NMI_SRC-1:0]    nmi_req,
  output logic                  n_nmi,
  output logic                  magic_mode,
  output logic                  magic_map,
  output logic [NMI_SRC-1:0]    nmi_cause,
  output logic [NUM_REGS*8-1:0] cfg,
  output logic [NUM_REGS-1:0]   cfg_wr,
  output logic [7:0]            d_out,
  output logic                  d_out_active
);

  localparam int           CW   = $clog2(NMI_TIMEOUT);
  localparam logic [CW-1:0] TMAX = CW'(NMI_TIMEOUT - 1);

  magic_state_t        state_q, state_d;
  logic                n_nmi_q, n_nmi_d;
  logic                mode_q, mode_d;
  logic                map_q, map_d;
  logic                exit_q, exit_d;
  logic [NMI_SRC-1:0]  cause_q, cause_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic                int_edge;
  logic [NMI_SRC-1:0]  elig;
  logic [NMI_SRC-1:0]  pick;
  logic                vec_fetch;
  logic                mem_rd;
  logic                cs;

  assign int_edge  = n_int && !n_int_next;
  assign elig      = nmi_req & (~SYNC_MASK | {NMI_SRC{int_edge}});
  assign pick      = elig & (~elig + NMI_SRC'(1));  // lowest set bit
  assign vec_fetch = bus.m1 && bus.memreq && (bus.a_reg == NMI_VECTOR);
  assign mem_rd    = bus.memreq && bus.rd;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACTIVE;
      n_nmi_q <= 1'b1;
      mode_q  <= 1'b1;
      map_q   <= 1'b1;
      exit_q  <= 1'b0;
      cause_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      n_nmi_q <= n_nmi_d;
      mode_q  <= mode_d;
      map_q   <= map_d;
      exit_q  <= exit_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_nmi_d = n_nmi_q;
    mode_d  = mode_q;
    map_d   = map_q;
    exit_d  = exit_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          state_d = ST_PENDING;
          n_nmi_d = 1'b0;
          mode_d  = 1'b1;
          cause_d = pick;
          cnt_d   = '0;
        end
      end
      ST_PENDING: begin
        // A vector fetch on the timeout cycle still takes the session.
        if (vec_fetch) begin
          state_d = ST_ACTIVE;
          n_nmi_d = 1'b1;
          map_d   = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == TMAX) begin
          state_d = ST_IDLE;
          n_nmi_d = 1'b1;
          mode_d  = 1'b0;
          cause_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ACTIVE: begin
        if (mem_rd && (bus.a_reg == EXIT_ADDR)) begin
          state_d = ST_UNMAP_WAIT;
          exit_d  = 1'b1;
          mode_d  = 1'b0;
        end else if (mem_rd && (bus.a_reg == REENTER_ADDR)) begin
          state_d = ST_UNMAP_WAIT;
          exit_d  = 1'b0;
        end
      end
      ST_UNMAP_WAIT: begin
        // Hold the map until the exit read's memory cycle has finished.
        if (!bus.memreq) begin
          map_d = 1'b0;
          if (exit_q) begin
            state_d = ST_IDLE;
            cause_d = '0;
          end else begin
            state_d = ST_REENTER;
          end
        end
      end
      ST_REENTER: begin
        if (bus.m1 && bus.memreq) begin
          state_d = ST_ACTIVE;
          map_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cs = map_q && bus.ioreq && (bus.a_reg[7:0] == MAGIC_CFG_PORT);

  magic_cfg_regs #(
    .NUM_REGS  (NUM_REGS),
    .CFG_RESET (CFG_RESET)
  ) u_cfg (
    .clk28          (clk28),
    .rst_n          (rst_n),
    .cs_i           (cs),
    .wr_i           (bus.wr),
    .rd_i           (bus.rd),
    .idx_i          (bus.a_reg[15:8]),
    .d_i            (bus.d_reg),
    .cause_i        (8'(cause_q)),
    .cfg_o          (cfg),
    .cfg_wr_o       (cfg_wr),
    .d_out_o        (d_out),
    .d_out_active_o (d_out_active)
  );

  assign n_nmi      = n_nmi_q;
  assign magic_mode = mode_q;
  assign magic_map  = map_q;
  assign nmi_cause  = cause_q;

endmodule

// File: tb/tb_magic_ctl.sv
// Directed bench for magic_ctl: boot, arbitration, sync mask, timeout, config port, reenter.
module tb_magic_ctl;
  localparam int           NMI_SRC  = 2;
  localparam int           NUM_REGS = 16;
  localparam logic [127:0] CFG_RST  = 128'h3F3E3D3C3B3A39383736353433323130;

  logic                  clk28 = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  n_int = 1'b1;
  logic                  n_int_next = 1'b1;
  logic [NMI_SRC-1:0]    nmi_req = '0;
  logic                  n_nmi, magic_mode, magic_map, d_out_active;
  logic [NMI_SRC-1:0]    nmi_cause;
  logic [NUM_REGS*8-1:0] cfg;
  logic [NUM_REGS-1:0]   cfg_wr;
  logic [7:0]            d_out;
  logic [127:0]          cfg_exp;

  int tests = 0;
  int fails = 0;

  cpu_bus bus_if();

  magic_ctl #(
    .NMI_SRC     (NMI_SRC),
    .SYNC_MASK   (2'b01),
    .NUM_REGS    (NUM_REGS),
    .CFG_RESET   (CFG_RST),
    .NMI_TIMEOUT (4096)
  ) dut (
    .clk28        (clk28),
    .rst_n        (rst_n),
    .bus          (bus_if),
    .n_int        (n_int),
    .n_int_next   (n_int_next),
    .nmi_req      (nmi_req),
    .n_nmi        (n_nmi),
    .magic_mode   (magic_mode),
    .magic_map    (magic_map),
    .nmi_cause    (nmi_cause),
    .cfg          (cfg),
    .cfg_wr       (cfg_wr),
    .d_out        (d_out),
    .d_out_active (d_out_active)
  );

  always #5 clk28 = ~clk28;

  task automatic tick();
    @(posedge clk28);
    #1;
  endtask

  task automatic bus_idle();
    bus_if.memreq = 1'b0; bus_if.ioreq = 1'b0; bus_if.m1 = 1'b0;
    bus_if.rd = 1'b0; bus_if.wr = 1'b0; bus_if.a_reg = 16'h0000; bus_if.d_reg = 8'h00;
  endtask

  task automatic mem_read(input logic [15:0] a, input logic m1);
    bus_idle();
    bus_if.memreq = 1'b1; bus_if.rd = 1'b1; bus_if.m1 = m1; bus_if.a_reg = a;
  endtask

  task automatic io_read(input logic [15:0] a);
    bus_idle();
    bus_if.ioreq = 1'b1; bus_if.rd = 1'b1; bus_if.a_reg = a;
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    bus_idle();
    bus_if.ioreq = 1'b1; bus_if.wr = 1'b1; bus_if.a_reg = a; bus_if.d_reg = d;
  endtask

  task automatic test_reset();
    bus_idle();
    rst_n = 1'b0;
    tick(); tick();
    tests++; if (magic_map !== 1'b1) begin fails++; $display("FAIL reset_map: got %0h exp 1", magic_map); end
    tests++; if (magic_mode !== 1'b1) begin fails++; $display("FAIL reset_mode: got %0h exp 1", magic_mode); end
    tests++; if (n_nmi !== 1'b1) begin fails++; $display("FAIL reset_nnmi: got %0h exp 1", n_nmi); end
    tests++; if (nmi_cause !== 2'b00) begin fails++; $display("FAIL reset_cause: got %0h exp 0", nmi_cause); end
    tests++; if (cfg !== CFG_RST) begin fails++; $display("FAIL reset_cfg: got %h exp %h", cfg, CFG_RST); end
    tests++; if (cfg_wr !== 16'h0000) begin fails++; $display("FAIL reset_cfgwr: got %h exp 0", cfg_wr); end
    tests++; if (d_out !== 8'hFF || d_out_active !== 1'b0) begin fails++; $display("FAIL reset_dout: got %h/%0h exp ff/0", d_out, d_out_active); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_boot_read();
    io_read(16'h00FF); tick();
    tests++; if (d_out !== 8'h30 || d_out_active !== 1'b1) begin fails++; $display("FAIL boot_rd0: got %h/%0h exp 30/1", d_out, d_out_active); end
    io_read(16'h05FF); tick();
    tests++; if (d_out !== 8'h35 || d_out_active !== 1'b1) begin fails++; $display("FAIL boot_rd5: got %h/%0h exp 35/1", d_out, d_out_active); end
    io_read(16'h20FF); tick();
    tests++; if (d_out_active !== 1'b0) begin fails++; $display("FAIL rd_oob: got %0h exp 0", d_out_active); end
    bus_idle(); tick();
    tests++; if (d_out_active !== 1'b0 || d_out !== 8'hFF) begin fails++; $display("FAIL rd_drop: got %h/%0h exp ff/0", d_out, d_out_active); end
  endtask

  task automatic test_exit();
    mem_read(16'hF000, 1'b0); tick();
    tests++; if (magic_mode !== 1'b0 || magic_map !== 1'b1) begin fails++; $display("FAIL exit_mode: got mode %0h map %0h exp 0/1", magic_mode, magic_map); end
    tick();
    tests++; if (magic_map !== 1'b1) begin fails++; $display("FAIL exit_hold: got %0h exp 1", magic_map); end
    bus_idle(); tick();
    tests++; if (magic_map !== 1'b0) begin fails++; $display("FAIL exit_unmap: got %0h exp 0", magic_map); end
  endtask

  task automatic test_arbitration();
    nmi_req = 2'b11; n_int = 1'b1; n_int_next = 1'b0; tick();
    nmi_req = 2'b00; n_int_next = 1'b1;
    tests++; if (n_nmi !== 1'b0 || nmi_cause !== 2'b01 || magic_mode !== 1'b1) begin fails++; $display("FAIL arb_trig: got nnmi %0h cause %0h mode %0h exp 0/1/1", n_nmi, nmi_cause, magic_mode); end
    mem_read(16'h0066, 1'b1); tick();
    tests++; if (n_nmi !== 1'b1 || magic_map !== 1'b1) begin fails++; $display("FAIL arb_vec: got nnmi %0h map %0h exp 1/1", n_nmi, magic_map); end
    io_read(16'hFFFF); tick();
    tests++; if (d_out !== 8'h01 || d_out_active !== 1'b1) begin fails++; $display("FAIL arb_cause_rd: got %h/%0h exp 01/1", d_out, d_out_active); end
    bus_idle(); tick();
  endtask

  task automatic test_cfg_write();
    cfg_exp = CFG_RST;
    cfg_exp[31:24] = 8'hA5;
    io_write(16'h03FF, 8'hA5); tick();
    tests++; if (cfg[31:24] !== 8'hA5) begin fails++; $display("FAIL wr_val: got %h exp a5", cfg[31:24]); end
    tests++; if (cfg_wr !== 16'h0008) begin fails++; $display("FAIL wr_strobe: got %h exp 0008", cfg_wr); end
    tick();
    tests++; if (cfg_wr !== 16'h0000) begin fails++; $display("FAIL wr_pulse: got %h exp 0000", cfg_wr); end
    io_write(16'h20FF, 8'h77); tick();
    tests++; if (cfg !== cfg_exp || cfg_wr !== 16'h0000) begin fails++; $display("FAIL wr_oob: got %h exp %h", cfg, cfg_exp); end
    io_read(16'h03FF); tick();
    tests++; if (d_out !== 8'hA5 || d_out_active !== 1'b1) begin fails++; $display("FAIL wr_readback: got %h/%0h exp a5/1", d_out, d_out_active); end
    mem_read(16'hF000, 1'b0); tick();
    bus_idle(); tick();
    io_write(16'h03FF, 8'h5A); tick();
    tests++; if (cfg[31:24] !== 8'hA5 || cfg_wr !== 16'h0000) begin fails++; $display("FAIL wr_unmapped: got %h/%h exp a5/0000", cfg[31:24], cfg_wr); end
    io_read(16'h03FF); tick();
    tests++; if (d_out_active !== 1'b0) begin fails++; $display("FAIL rd_unmapped: got %0h exp 0", d_out_active); end
    bus_idle(); tick();
  endtask

  task automatic test_sync_mask();
    nmi_req = 2'b01; n_int = 1'b0; n_int_next = 1'b0; tick(); tick();
    tests++; if (n_nmi !== 1'b1) begin fails++; $display("FAIL sync_low: got %0h exp 1", n_nmi); end
    n_int = 1'b1; n_int_next = 1'b1; tick();
    tests++; if (n_nmi !== 1'b1) begin fails++; $display("FAIL sync_high: got %0h exp 1", n_nmi); end
    nmi_req = 2'b11; tick();
    nmi_req = 2'b00;
    tests++; if (n_nmi !== 1'b0 || nmi_cause !== 2'b10) begin fails++; $display("FAIL unsync_src1: got nnmi %0h cause %0h exp 0/2", n_nmi, nmi_cause); end
  endtask

  task automatic test_timeout();
    repeat (4095) tick();
    tests++; if (n_nmi !== 1'b0 || magic_mode !== 1'b1) begin fails++; $display("FAIL tmo_early: got nnmi %0h mode %0h exp 0/1", n_nmi, magic_mode); end
    tick();
    tests++; if (n_nmi !== 1'b1 || magic_mode !== 1'b0 || nmi_cause !== 2'b00) begin fails++; $display("FAIL tmo_fire: got nnmi %0h mode %0h cause %0h exp 1/0/0", n_nmi, magic_mode, nmi_cause); end
    nmi_req = 2'b10; tick();
    nmi_req = 2'b00;
    tests++; if (n_nmi !== 1'b0) begin fails++; $display("FAIL tmo_idle: got %0h exp 0", n_nmi); end
  endtask

  task automatic test_reenter();
    mem_read(16'h0066, 1'b1); tick();
    tests++; if (n_nmi !== 1'b1 || magic_map !== 1'b1) begin fails++; $display("FAIL re_vec: got nnmi %0h map %0h exp 1/1", n_nmi, magic_map); end
    mem_read(16'hF008, 1'b0); tick();
    tests++; if (magic_map !== 1'b1 || magic_mode !== 1'b1) begin fails++; $display("FAIL re_read: got map %0h mode %0h exp 1/1", magic_map, magic_mode); end
    bus_idle(); tick();
    tests++; if (magic_map !== 1'b0 || magic_mode !== 1'b1) begin fails++; $display("FAIL re_unmap: got map %0h mode %0h exp 0/1", magic_map, magic_mode); end
    tick();
    tests++; if (magic_map !== 1'b0) begin fails++; $display("FAIL re_wait: got %0h exp 0", magic_map); end
    mem_read(16'h1234, 1'b1); tick();
    tests++; if (magic_map !== 1'b1 || magic_mode !== 1'b1) begin fails++; $display("FAIL re_remap: got map %0h mode %0h exp 1/1", magic_map, magic_mode); end
    bus_idle(); nmi_req = 2'b10; tick();
    tests++; if (n_nmi !== 1'b1) begin fails++; $display("FAIL ign_active: got %0h exp 1", n_nmi); end
    mem_read(16'hF000, 1'b0); tick();
    tests++; if (magic_mode !== 1'b0 || n_nmi !== 1'b1) begin fails++; $display("FAIL exit_vs_trig: got mode %0h nnmi %0h exp 0/1", magic_mode, n_nmi); end
    nmi_req = 2'b00; bus_idle(); tick();
    tests++; if (magic_map !== 1'b0) begin fails++; $display("FAIL exit2_unmap: got %0h exp 0", magic_map); end
    tick();
    tests++; if (n_nmi !== 1'b1) begin fails++; $display("FAIL not_queued: got %0h exp 1", n_nmi); end
  endtask

  task automatic test_reset_mid();
    nmi_req = 2'b10; tick();
    nmi_req = 2'b00;
    tests++; if (n_nmi !== 1'b0) begin fails++; $display("FAIL mid_trig: got %0h exp 0", n_nmi); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (n_nmi !== 1'b1 || magic_map !== 1'b1 || magic_mode !== 1'b1 || nmi_cause !== 2'b00) begin fails++; $display("FAIL mid_rst_fsm: got nnmi %0h map %0h mode %0h cause %0h exp 1/1/1/0", n_nmi, magic_map, magic_mode, nmi_cause); end
    tests++; if (cfg !== CFG_RST) begin fails++; $display("FAIL mid_rst_cfg: got %h exp %h", cfg, CFG_RST); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_boot_read();
    test_exit();
    test_arbitration();
    test_cfg_write();
    test_sync_mask();
    test_timeout();
    test_reenter();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
